// File: rtl/count_seq_checker.sv
// count_seq_checker: watches a 4-bit counter stream and checks that it
// advances by +1 (mod 16) on every valid sample. It declares lock after
// LOCK_LEN consecutive good steps, pulses err on a break while locked, and
// keeps saturating counts of errors and of 15->0 wraps seen while locked.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | no reference value yet; next valid sample seeds prev
//   SYNC  | counting consecutive good steps toward lock
//   TRACK | locked; a bad step raises err and drops back to SYNC
module count_seq_checker #(
  parameter int LOCK_LEN = 4,
  parameter int CW       = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [3:0]    in,
  input  logic          in_valid,
  input  logic          clr_cnt,
  output logic          locked,
  output logic          err,
  output logic [CW-1:0] err_cnt,
  output logic [CW-1:0] wrap_cnt,
  output logic [3:0]    last
);

  typedef enum logic [1:0] {IDLE, SYNC, TRACK} state_t;

  state_t        state_q, state_d;
  logic [3:0]    prev_q, prev_d;
  logic [3:0]    run_q, run_d;
  logic          locked_q, locked_d;
  logic          err_q, err_d;
  logic [CW-1:0] err_cnt_q, err_cnt_d;
  logic [CW-1:0] wrap_cnt_q, wrap_cnt_d;
  logic [3:0]    last_q, last_d;

  logic [3:0]    expect_val;
  logic [3:0]    run_inc;
  logic          good_step;
  logic          err_inc;
  logic          wrap_inc;

  assign expect_val = prev_q + 4'd1;
  assign run_inc    = run_q + 4'd1;
  assign good_step  = (in == expect_val);

  // Next-state and next-output logic; everything holds unless a valid sample arrives.
  always_comb begin
    state_d  = state_q;
    prev_d   = prev_q;
    run_d    = run_q;
    locked_d = locked_q;
    last_d   = last_q;
    err_d    = 1'b0;
    err_inc  = 1'b0;
    wrap_inc = 1'b0;

    if (in_valid) begin
      prev_d = in;
      last_d = in;
      case (state_q)
        IDLE: begin
          run_d    = 4'd0;
          locked_d = 1'b0;
          state_d  = SYNC;
        end
        SYNC: begin
          if (good_step) begin
            if (run_inc == 4'(LOCK_LEN)) begin
              run_d    = 4'd0;
              locked_d = 1'b1;
              state_d  = TRACK;
            end else begin
              run_d = run_inc;
            end
          end else begin
            run_d = 4'd0;
          end
        end
        TRACK: begin
          if (good_step) begin
            wrap_inc = (prev_q == 4'd15) && (in == 4'd0);
          end else begin
            err_d    = 1'b1;
            err_inc  = 1'b1;
            locked_d = 1'b0;
            run_d    = 4'd0;
            state_d  = SYNC;
          end
        end
        default: begin
          state_d  = IDLE;
          locked_d = 1'b0;
          run_d    = 4'd0;
        end
      endcase
    end

    // Counters saturate at all-ones; a clear beats any simultaneous increment.
    err_cnt_d  = err_cnt_q;
    wrap_cnt_d = wrap_cnt_q;
    if (clr_cnt) begin
      err_cnt_d  = '0;
      wrap_cnt_d = '0;
    end else begin
      if (err_inc && (err_cnt_q != {CW{1'b1}}))
        err_cnt_d = err_cnt_q + 1'b1;
      if (wrap_inc && (wrap_cnt_q != {CW{1'b1}}))
        wrap_cnt_d = wrap_cnt_q + 1'b1;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      prev_q     <= 4'd0;
      run_q      <= 4'd0;
      locked_q   <= 1'b0;
      err_q      <= 1'b0;
      err_cnt_q  <= '0;
      wrap_cnt_q <= '0;
      last_q     <= 4'd0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      run_q      <= run_d;
      locked_q   <= locked_d;
      err_q      <= err_d;
      err_cnt_q  <= err_cnt_d;
      wrap_cnt_q <= wrap_cnt_d;
      last_q     <= last_d;
    end
  end

  assign locked   = locked_q;
  assign err      = err_q;
  assign err_cnt  = err_cnt_q;
  assign wrap_cnt = wrap_cnt_q;
  assign last     = last_q;

endmodule

// File: doc/count_seq_checker.md
COUNT_SEQ_CHECKER -- requirements
Module: count_seq_checker

Interface
REQ-001 Parameter: LOCK_LEN, default 4, consecutive +1 steps required to declare lock (legal range 1..15).
REQ-002 Parameter: CW, default 8, width of err_cnt and wrap_cnt.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-low reset.
REQ-005 Port: in  input  4  count value from the upstream 4-bit counter.
REQ-006 Port: in_valid  input  1  in is sampled only on edges where in_valid=1.
REQ-007 Port: clr_cnt  input  1  synchronous clear of err_cnt and wrap_cnt; lock state unaffected.
REQ-008 Port: locked  output  1  high while the stream tracks a +1 modulo-16 sequence.
REQ-009 Port: err  output  1  one-cycle pulse on a sequence break while locked.
REQ-010 Port: err_cnt  output  CW  saturating count of err pulses.
REQ-011 Port: wrap_cnt  output  CW  saturating count of 15->0 wraps seen while locked.
REQ-012 Port: last  output  4  last sampled value of in.

Function
REQ-013 FSM states: IDLE, SYNC, TRACK; internal regs prev[3:0], run[3:0].
REQ-014 All outputs registered; effect of a sample is visible on outputs after the edge that samples it (latency 1 cycle).
REQ-015 "Good step": in == (prev+1) mod 16, 4-bit wrap arithmetic (15->0 good).
REQ-016 in_valid=0: state, prev, run, locked, counters, last all hold; err=0.
REQ-017 IDLE, valid sample: prev<=in, last<=in, run<=0, go SYNC; locked stays 0.
REQ-018 SYNC, valid good step: run<=run+1; if run+1==LOCK_LEN go TRACK and locked<=1, run<=0.
REQ-019 SYNC, valid bad step: run<=0, stay SYNC; no err pulse, err_cnt unchanged.
REQ-020 TRACK, valid good step: stay TRACK; if prev==15 and in==0, wrap_cnt<=wrap_cnt+1.
REQ-021 TRACK, valid bad step: err<=1 for one cycle, err_cnt<=err_cnt+1, locked<=0, run<=0, go SYNC.
REQ-022 Every valid sample in any state updates prev<=in and last<=in.
REQ-023 err_cnt and wrap_cnt saturate at 2^CW-1; never wrap to 0.
REQ-024 clr_cnt=1 forces both counters to 0 on that edge; clr_cnt wins over a simultaneous increment; err pulse still asserts.
REQ-025 err is 0 on every edge not covered by REQ-021.
REQ-026 Repeated value (in==prev) and backward steps are bad steps.

Reset
REQ-027 reset=0 at a rising edge: state<=IDLE; locked, err, err_cnt, wrap_cnt, last, prev, run all <=0.
REQ-028 reset has priority over in_valid and clr_cnt; reset mid-operation discards lock and counters.
REQ-029 First valid sample after reset release is treated as IDLE entry (REQ-017), never as a step.

Verification
REQ-030 LOCK_LEN=4; after reset, valid samples 0,1,2,3,4 on consecutive edges -> locked=1 after edge sampling 4, err=0 throughout, last=4.
REQ-031 Locked; samples 14,15,0,1 -> wrap_cnt=1 after edge sampling 0, locked stays 1, err=0.
REQ-032 Locked at prev=5; sample 7 -> err=1 for exactly one cycle, err_cnt=1, locked=0; then 8,9,10,11 -> locked=1 after 11.
REQ-033 Samples 0,1, in_valid=0 for 3 cycles, then 2,3,4 -> locked=1 after edge sampling 4; outputs unchanged during gap.
REQ-034 Locked with wrap_cnt=3, err_cnt=2; drive reset=0 one edge -> all outputs 0 next cycle, state IDLE; sample 9 next -> no err, locked=0.
REQ-035 CW=8; force 300 errors -> err_cnt holds 255; assert clr_cnt on an error edge -> err=1, err_cnt=0.
